// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, FSM states and byte-enable helper for data_memory_unit
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  // Lane mask for an access of the given size starting at byte lane off
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    base = size == SZ_BYTE ? 8'h01 : size == SZ_HALF ? 8'h03 : size == SZ_WORD ? 8'h0f : 8'hff;
    return base << off;
  endfunction
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: shifts the addressed lanes of a memory word down to bit 0
// and sign- or zero-extends them to DATA_W
module dmem_load_align import dmem_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [2:0]        i_off,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_data
);
  logic [DATA_W-1:0] w_sh, w_mask, w_top;
  logic              w_sign;

  // A full-width mask leaves ~w_mask empty, so Unsigned has no effect there
  always_comb begin
    w_sh   = i_word >> {i_off, 3'b000};
    w_mask = i_size == SZ_BYTE ? DATA_W'(8'hff) :
             i_size == SZ_HALF ? DATA_W'(16'hffff) :
             i_size == SZ_WORD ? DATA_W'(32'hffff_ffff) : '1;
    w_top  = w_mask & ~(w_mask >> 1);
    w_sign = !i_unsigned && |(w_sh & w_top);
    o_data = (w_sh & w_mask) | (w_sign ? ~w_mask : '0);
  end
endmodule

// File: rtl/data_memory_unit.sv
// data_memory_unit: byte-addressed data memory with sub-word access, error
// checking and a configurable wait-state request/response handshake
module data_memory_unit import dmem_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_address,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [1:0]        i_size,
  input  logic              i_unsigned,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_read_data,
  output logic              o_read_valid,
  output logic              o_error
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] LIMIT    = 33'(DEPTH * NB);
  localparam logic [3:0]  CNT_INIT = WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e            r_state, w_next;
  logic [3:0]        r_cnt;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [1:0]        r_size;
  logic              r_uns, r_rd, r_wr, r_valid, r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept, w_resp, w_err, w_we;
  logic [AW-1:0]     w_idx;
  logic [2:0]        w_off;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wsh, w_load;

  assign w_accept = (i_mem_read | i_mem_write) && o_ready;
  assign w_resp   = r_state == RESP;
  assign w_idx    = r_addr[LB +: AW];
  assign w_off    = 3'(r_addr[LB-1:0]);
  assign w_be     = NB'(byte_mask(r_size, w_off));
  assign w_wsh    = r_wdata << {w_off, 3'b000};
  assign w_err    = (r_rd && r_wr) ||
                    (r_size == SZ_DWORD && DATA_W == 32) ||
                    (r_size == SZ_HALF && r_addr[0]) ||
                    (r_size == SZ_WORD && |r_addr[1:0]) ||
                    (r_size == SZ_DWORD && |r_addr[2:0]) ||
                    ({1'b0, r_addr} >= LIMIT);
  assign w_we     = w_resp && r_wr && !w_err;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else r_state <= w_next;

  // RESP accepts like IDLE so back-to-back requests need no idle cycle
  always_comb
    w_next = r_state == WAIT ? (r_cnt == 4'd0 ? RESP : WAIT) :
             w_accept ? (WAIT_STATES > 0 ? WAIT : RESP) : IDLE;

  always_comb o_ready = r_state != WAIT;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= SZ_BYTE;
      r_uns   <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_INIT;
        r_addr  <= i_address;
        r_wdata <= i_write_data;
        r_size  <= i_size;
        r_uns   <= i_unsigned;
        r_rd    <= i_mem_read;
        r_wr    <= i_mem_write;
      end else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      r_valid <= w_resp && r_rd && !w_err;
      r_err   <= w_resp && w_err;
      if (w_resp && r_rd && !w_err) r_rdata <= w_load;
    end

  always_ff @(posedge i_clk)
    for (int b = 0; b < NB; b++)
      if (w_we && w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wsh[8*b +: 8];

  dmem_load_align #(.DATA_W(DATA_W)) u_align (
    .i_word    (r_mem[w_idx]),
    .i_off     (w_off),
    .i_size    (r_size),
    .i_unsigned(r_uns),
    .o_data    (w_load)
  );

  assign o_read_data  = r_rdata;
  assign o_read_valid = r_valid;
  assign o_error      = r_err;
endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Parametrised data memory for the single-cycle/pipelined MIPS datapath. It replaces the fixed 128×32 word-only memory with several capabilities: configurable width and depth, byte-addressed sub-word loads and stores (byte/half/word, signed or unsigned), alignment and range checking, and a configurable wait-state handshake so the pipeline can stall on a slow memory. It sits between the ALU address output and the write-back mux.

## Interface
- DATA_W, 32, word width in bits; legal values 32 or 64
- DEPTH, 128, number of DATA_W words; power of two
- WAIT_STATES, 0, extra cycles between request acceptance and completion (0–15)
- Clk  in  1  rising-edge clock
- Rst_n  in  1  reset, asynchronous, active-low
- Address  in  32  byte address
- WriteData  in  DATA_W  store data, right-justified for sub-word stores
- MemRead  in  1  load request
- MemWrite  in  1  store request
- Size  in  2  00 byte, 01 half, 10 word, 11 doubleword (legal only when DATA_W=64)
- Unsigned  in  1  1 = zero-extend loads, 0 = sign-extend
- Ready  out  1  1 = request accepted this cycle if presented
- ReadData  out  DATA_W  aligned, extended load result
- ReadValid  out  1  one-cycle pulse, ReadData updated
- Error  out  1  one-cycle pulse, request rejected

## Operation
- Accept: (MemRead | MemWrite) && Ready at a rising edge. On accept, Address, WriteData, Size, Unsigned and direction are registered.
- FSM states:
  - IDLE: Ready=1. On accept, go to WAIT if WAIT_STATES>0, else go to RESP.
  - WAIT: Ready=0. Down-counter loaded with WAIT_STATES-1; go to RESP at 0.
  - RESP: perform the access; pulse ReadValid or Error; Ready=1. An accept in RESP behaves as an accept in IDLE, so back-to-back requests are allowed. Otherwise go to IDLE.
- Word index = Address[LB +: log2(DEPTH)], where LB = log2(DATA_W/8). Lane offset = Address[LB-1:0].
- Error conditions. Any of these raises Error in RESP with no memory update, ReadValid=0 and ReadData unchanged:
  - MemRead && MemWrite
  - Size=11 with DATA_W=32
  - half not 2-aligned
  - word not 4-aligned
  - doubleword not 8-aligned
  - Address ≥ DEPTH·DATA_W/8
- Store: only the addressed lanes are written. Byte writes WriteData[7:0]; half writes [15:0]; word writes [31:0]; doubleword writes all lanes. All other lanes are preserved.
- Load: extract the addressed lanes, shift them to bit 0, then sign- or zero-extend per Unsigned to DATA_W. For a full-width Size, Unsigned is ignored.
- Memory array contents are not reset (undefined until written).

## Timing
- Reset values: Ready=1, ReadValid=0, Error=0, ReadData=0, FSM=IDLE, counter=0.
- Latency: completion occurs WAIT_STATES+1 edges after the accepting edge. ReadData/ReadValid/Error are registered and appear after that edge.
- A store commits at the same completion edge. A load to the same address accepted in the completing cycle returns the new data (read-after-write ordering by sequencing).
- Throughput: with WAIT_STATES=0, one request per cycle and Ready is constantly 1. Otherwise, one request per WAIT_STATES+1 cycles.
- Requests presented while Ready=0 are ignored. The requester must hold them until accepted.
- ReadData holds its value between load responses. Writes and Errors do not alter it.
- Reset asserted mid-operation aborts immediately: a pending store is dropped and no response pulse follows. Reset deassertion is synchronised by the user.

## Structure
- dmem_pkg holds:
  - Size encodings: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD
  - FSM state enum: IDLE, WAIT, RESP
  - a function computing the byte-enable mask from Size and lane offset
- Sub-module dmem_load_align is a combinational lane extract plus sign/zero extension, parametrised by DATA_W. The top instantiates it once on the array read port.
- Top holds the FSM, wait counter, request registers, byte-masked array write, and the error checker.

## Test plan
- Word round trip: WAIT_STATES=0, store 0xDEADBEEF at 0x10, then load word at 0x10 → ReadValid on the next edge with ReadData=0xDEADBEEF; back-to-back, Ready never drops.
- Sub-word loads: load byte at 0x13 signed → 0xFFFFFFDE; unsigned → 0x000000DE. Load half at 0x10 signed → 0xFFFFBEEF.
- Byte store merge: store byte 0x55 at 0x11 over 0xDEADBEEF → a word load returns 0xDEAD55EF.
- Errors: half load at 0x11, word store at 0x202 (DEPTH=128), and MemRead&MemWrite each → one Error pulse, no ReadValid, memory and ReadData unchanged.
- Wait states: WAIT_STATES=3, load → Ready low for 3 cycles, ReadValid 4 edges after accept; a request held during Ready=0 is accepted exactly once.
- Reset abort: WAIT_STATES=3, store 0x12345678 to 0x20, assert Rst_n low in WAIT → outputs return to reset values at once; a later load of 0x20 does not return 0x12345678 (preloaded 0).
